bcd_multiplier: RTL and testbench

- Registered single-digit BCD multiplier: two BCD digits (0-9) in, one two-digit packed BCD product (00-81) out.
- Output viewed in hex reads as the decimal product, e.g. 7*8 -> 8'h56.
- Leaf arithmetic block for BCD datapaths; one clock domain; 1-cycle latency from input capture to output.

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_bin7_to_bcd2.sv | 25 ++
 rtl/bcd_multiplier.sv | 66 ++++++
 tb/tb_bcd_multiplier.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for single-digit BCD arithmetic blocks.
//   BCD_DIGIT_W   : width of one BCD digit
//   BCD_MAX_DIGIT : largest legal BCD digit value
//   bcd_digit_t   : one 4-bit BCD digit
//   bcd_pair_t    : packed two-digit BCD value, tens in [7:4], units in [3:0]
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t tens;
    bcd_digit_t units;
  } bcd_pair_t;

endpackage

// File: rtl/bcd_bin7_to_bcd2.sv
// Combinational 7-bit binary to two-digit packed BCD converter (shift-add-3).
// Exact for inputs 0..99; larger inputs give an unspecified BCD-shaped value.
//   bin_i : binary value, 0..99
//   bcd_o : packed BCD result {tens, units}
module bcd_bin7_to_bcd2
  import bcd_pkg::*;
(
  input  logic [6:0] bin_i,
  output bcd_pair_t  bcd_o
);

  // Scratch layout: [14:11] tens, [10:7] units, [6:0] remaining binary bits.
  logic [14:0] scratch;

  always_comb begin
    scratch = {8'b0, bin_i};
    for (int unsigned i = 0; i < 7; i++) begin
      if (scratch[10:7] >= 4'd5) scratch[10:7] = scratch[10:7] + 4'd3;
      if (scratch[14:11] >= 4'd5) scratch[14:11] = scratch[14:11] + 4'd3;
      scratch = scratch << 1;
    end
    bcd_o = scratch[14:7];
  end

endmodule

// File: rtl/bcd_multiplier.sv
// Registered single-digit BCD multiplier with 1-cycle latency.
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   in_valid  : qualifies num1/num2 on the current edge
//   num1,num2 : BCD operand digits
//   res       : packed BCD product {tens, units}, 8'h00 on invalid operands
//   out_valid : res/err carry the result of the operands accepted last edge
//   err       : last accepted operand pair had a digit above 9
module bcd_multiplier
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] num1,
  input  logic [3:0] num2,
  output logic [7:0] res,
  output logic       out_valid,
  output logic       err
);

  logic      operands_ok;
  logic [6:0] product;
  bcd_pair_t product_bcd;

  bcd_pair_t res_d, res_q;
  logic      err_d, err_q;
  logic      vld_d, vld_q;

  assign operands_ok = (num1 <= BCD_MAX_DIGIT) && (num2 <= BCD_MAX_DIGIT);
  // Only the valid-operand range (max 81) must be exact; wider products are masked.
  assign product     = {3'b0, num1} * {3'b0, num2};

  bcd_bin7_to_bcd2 u_conv (
    .bin_i (product),
    .bcd_o (product_bcd)
  );

  always_comb begin
    res_d = res_q;
    err_d = err_q;
    vld_d = 1'b0;
    if (in_valid) begin
      vld_d = 1'b1;
      err_d = ~operands_ok;
      res_d = operands_ok ? product_bcd : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q <= '0;
      err_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      res_q <= res_d;
      err_q <= err_d;
      vld_q <= vld_d;
    end
  end

  assign res       = res_q;
  assign err       = err_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_bcd_multiplier.sv
// Directed self-checking bench for bcd_multiplier with an expected-result queue.
module tb_bcd_multiplier;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] num1;
  logic [3:0] num2;
  logic [7:0] res;
  logic       out_valid;
  logic       err;

  typedef struct {
    logic [7:0] res;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] hold_res = 8'h00;
  logic       hold_err = 1'b0;

  bcd_multiplier dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .num1      (num1),
    .num2      (num2),
    .res       (res),
    .out_valid (out_valid),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    int   p;
    if (a > 9 || b > 9) begin
      e.res = 8'h00;
      e.err = 1'b1;
    end else begin
      p = int'(a) * int'(b);
      e.res = 8'((p / 10) * 16 + (p % 10));
      e.err = 1'b0;
    end
    return e;
  endfunction

  // Drive one cycle of stimulus, then check the outputs 1 time unit after the edge.
  task automatic step(input logic [3:0] a, input logic [3:0] b, input logic v, input string tag);
    exp_t e;
    num1     = a;
    num2     = b;
    in_valid = v;
    if (v) sb.push_back(model(a, b));
    @(posedge clk);
    #1;
    check({tag, ".out_valid"}, {7'b0, out_valid}, {7'b0, v});
    if (sb.size() > 0) begin
      e = sb.pop_front();
      hold_res = e.res;
      hold_err = e.err;
      check({tag, ".res"}, res, e.res);
      check({tag, ".err"}, {7'b0, err}, {7'b0, e.err});
    end else begin
      check({tag, ".hold_res"}, res, hold_res);
      check({tag, ".hold_err"}, {7'b0, err}, {7'b0, hold_err});
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    num1     = 4'd0;
    num2     = 4'd0;
    #1;
    check("reset.res", res, 8'h00);
    check("reset.out_valid", {7'b0, out_valid}, 8'h00);
    check("reset.err", {7'b0, err}, 8'h00);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Exhaustive valid sweep, back to back
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < 10; j++)
        step(4'(i), 4'(j), 1'b1, $sformatf("mul_%0d_%0d", i, j));

    // Spot checks against literal constants
    step(4'd7, 4'd8, 1'b1, "lit_7x8");
    check("lit_7x8.const", res, 8'h56);
    step(4'd9, 4'd9, 1'b1, "lit_9x9");
    check("lit_9x9.const", res, 8'h81);

    // Invalid digits
    step(4'hA, 4'd3, 1'b1, "inv_A_3");
    check("inv_A_3.err_const", {7'b0, err}, 8'h01);
    step(4'd2, 4'hF, 1'b1, "inv_2_F");
    step(4'hA, 4'd0, 1'b1, "inv_A_0");
    check("inv_A_0.err_const", {7'b0, err}, 8'h01);
    step(4'd6, 4'd7, 1'b1, "after_inv_6x7");
    check("after_inv_6x7.const", res, 8'h42);

    // Hold
    step(4'd6, 4'd6, 1'b1, "hold_load");
    step(4'd9, 4'd9, 1'b0, "hold_idle");
    check("hold_idle.const", res, 8'h36);
    step(4'd1, 4'd1, 1'b0, "hold_idle2");

    // Async reset between edges discards the held result
    step(4'd8, 4'd9, 1'b1, "pre_rst_8x9");
    #2;
    rst = 1'b1;
    #1;
    check("async_rst.res", res, 8'h00);
    check("async_rst.out_valid", {7'b0, out_valid}, 8'h00);
    check("async_rst.err", {7'b0, err}, 8'h00);
    sb.delete();
    hold_res = 8'h00;
    hold_err = 1'b0;
    #1;
    rst = 1'b0;
    step(4'd2, 4'd5, 1'b1, "post_rst_2x5");
    check("post_rst_2x5.const", res, 8'h10);

    // Back-to-back throughput
    step(4'd1, 4'd1, 1'b1, "b2b_1x1");
    check("b2b_1x1.const", res, 8'h01);
    step(4'd2, 4'd9, 1'b1, "b2b_2x9");
    check("b2b_2x9.const", res, 8'h18);
    step(4'd9, 4'd2, 1'b1, "b2b_9x2");
    check("b2b_9x2.const", res, 8'h18);
    step(4'd4, 4'd5, 1'b1, "b2b_4x5");
    check("b2b_4x5.const", res, 8'h20);
    step(4'd0, 4'd0, 1'b0, "drain");

    check("scoreboard_empty", 8'(sb.size()), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net against a stalled run
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
